// File: rtl/ir_timer_n.sv
// IR-remote controlled BCD timer: free-running up counter plus a settable countdown.
// Keys arrive as ir_in[23:16] qualified by ir_ready; every clk_1HZ edge is one tick.
module ir_timer_n #(
    parameter int         DIGITS      = 4,
    parameter logic [7:0] KEY_MODE    = 8'h11,
    parameter logic [7:0] KEY_START   = 8'h16,
    parameter logic [7:0] KEY_CLEAR   = 8'h10,
    parameter bit         AUTO_RELOAD = 1'b0
) (
    input  logic                  clk_1HZ,
    input  logic                  rst,
    input  logic                  ir_ready,
    input  logic [31:0]           ir_in,
    output logic [4*DIGITS-1:0]   digits,
    output logic [4*DIGITS-1:0]   preset,
    output logic [2:0]            state,
    output logic                  done,
    output logic                  wrap
);

    localparam int W = 4 * DIGITS;
    localparam logic [W-1:0] BCD_ZERO = {W{1'b0}};
    localparam logic [W-1:0] BCD_ONE  = {{(W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        UP_RUN    = 3'd0,
        UP_HOLD   = 3'd1,
        SET       = 3'd2,
        DOWN_RUN  = 3'd3,
        DOWN_HOLD = 3'd4,
        DONE      = 3'd5
    } state_t;

    // Ripple-carry BCD increment; the MSB of the result is the carry out of the top digit.
    function automatic logic [W:0] bcd_inc(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         c;
        r = {W{1'b0}};
        c = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (c) begin
                if (v[4*i +: 4] >= 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                    c = 1'b1;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    c = 1'b0;
                end
            end else begin
                r[4*i +: 4] = v[4*i +: 4];
            end
        end
        return {c, r};
    endfunction

    // Ripple-borrow BCD decrement; a zero digit borrows and becomes 9.
    function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         b;
        r = {W{1'b0}};
        b = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (b) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                    b = 1'b1;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    b = 1'b0;
                end
            end else begin
                r[4*i +: 4] = v[4*i +: 4];
            end
        end
        return r;
    endfunction

    state_t       state_r, state_s;
    logic [W-1:0] digits_r, digits_s;
    logic [W-1:0] preset_r, preset_s;
    logic         done_r, done_s;
    logic         wrap_r, wrap_s;

    logic [7:0]   key_code_s;
    logic         is_mode_s, is_clear_s, is_start_s, is_digit_s;
    logic [W-1:0] inc_val_s, dec_val_s, preset_shift_s;
    logic         inc_carry_s;
    logic         unused_s;

    assign key_code_s = ir_in[23:16];
    assign unused_s   = ^{ir_in[31:24], ir_in[15:0]};

    // Fixed priority: mode beats clear beats start beats digit keys.
    assign is_mode_s  = ir_ready && (key_code_s == KEY_MODE);
    assign is_clear_s = ir_ready && !is_mode_s && (key_code_s == KEY_CLEAR);
    assign is_start_s = ir_ready && !is_mode_s && !is_clear_s && (key_code_s == KEY_START);
    assign is_digit_s = ir_ready && !is_mode_s && !is_clear_s && !is_start_s
                        && (key_code_s <= 8'h09);

    assign {inc_carry_s, inc_val_s} = bcd_inc(digits_r);
    assign dec_val_s = bcd_dec(digits_r);

    if (DIGITS > 1) begin : g_shift_multi
        assign preset_shift_s = {preset_r[W-5:0], key_code_s[3:0]};
    end else begin : g_shift_single
        assign preset_shift_s = key_code_s[3:0];
    end

    // Next-state, next-count and pulse decode for the timer FSM.
    always_comb begin
        state_s  = state_r;
        digits_s = digits_r;
        preset_s = preset_r;
        done_s   = 1'b0;
        wrap_s   = 1'b0;
        case (state_r)
            UP_RUN, UP_HOLD: begin
                if (is_mode_s) begin
                    state_s  = SET;
                    digits_s = BCD_ZERO;
                    preset_s = BCD_ZERO;
                end else if (is_clear_s) begin
                    digits_s = BCD_ZERO;
                end else if (is_start_s) begin
                    state_s = (state_r == UP_RUN) ? UP_HOLD : UP_RUN;
                end else if (state_r == UP_RUN) begin
                    digits_s = inc_val_s;
                    wrap_s   = inc_carry_s;
                end else begin
                    digits_s = digits_r;
                end
            end
            SET: begin
                if (is_mode_s) begin
                    state_s  = UP_RUN;
                    digits_s = BCD_ZERO;
                end else if (is_clear_s) begin
                    digits_s = BCD_ZERO;
                    preset_s = BCD_ZERO;
                end else if (is_start_s) begin
                    if (preset_r != BCD_ZERO) begin
                        state_s  = DOWN_RUN;
                        digits_s = preset_r;
                    end else begin
                        state_s = SET;
                    end
                end else if (is_digit_s) begin
                    preset_s = preset_shift_s;
                    digits_s = preset_shift_s;
                end else begin
                    state_s = SET;
                end
            end
            DOWN_RUN, DOWN_HOLD: begin
                if (is_mode_s) begin
                    state_s  = UP_RUN;
                    digits_s = BCD_ZERO;
                end else if (is_clear_s) begin
                    state_s  = SET;
                    digits_s = BCD_ZERO;
                    preset_s = BCD_ZERO;
                end else if (is_start_s) begin
                    state_s = (state_r == DOWN_RUN) ? DOWN_HOLD : DOWN_RUN;
                end else if (state_r == DOWN_HOLD) begin
                    digits_s = digits_r;
                end else if ((digits_r == BCD_ONE) || (digits_r == BCD_ZERO)) begin
                    // Zero is unreachable here but must not underflow to all-9s.
                    state_s  = DONE;
                    digits_s = BCD_ZERO;
                    done_s   = 1'b1;
                end else begin
                    digits_s = dec_val_s;
                end
            end
            DONE: begin
                if (is_mode_s) begin
                    state_s  = UP_RUN;
                    digits_s = BCD_ZERO;
                end else if (AUTO_RELOAD) begin
                    state_s  = DOWN_RUN;
                    digits_s = preset_r;
                end else begin
                    state_s  = SET;
                    digits_s = BCD_ZERO;
                end
            end
            default: begin
                state_s  = UP_RUN;
                digits_s = BCD_ZERO;
                preset_s = BCD_ZERO;
            end
        endcase
    end

    // State, count, preset and pulse registers with synchronous reset.
    always_ff @(posedge clk_1HZ) begin
        if (rst) begin
            state_r  <= UP_RUN;
            digits_r <= BCD_ZERO;
            preset_r <= BCD_ZERO;
            done_r   <= 1'b0;
            wrap_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            digits_r <= digits_s;
            preset_r <= preset_s;
            done_r   <= done_s;
            wrap_r   <= wrap_s;
        end
    end

    assign digits = digits_r;
    assign preset = preset_r;
    assign state  = state_r;
    assign done   = done_r;
    assign wrap   = wrap_r;

endmodule

// File: tb/tb_ir_timer_n.sv
// Scoreboard bench for ir_timer_n: two instances (AUTO_RELOAD 0 and 1) share stimulus,
// a decimal-arithmetic reference model predicts each edge, a monitor compares.
module tb_ir_timer_n;

    localparam int         MOD     = 10000;
    localparam logic [7:0] K_MODE  = 8'h11;
    localparam logic [7:0] K_START = 8'h16;
    localparam logic [7:0] K_CLEAR = 8'h10;

    logic        clk_1HZ = 1'b0;
    logic        rst = 1'b1;
    logic        ir_ready = 1'b0;
    logic [31:0] ir_in = 32'h0;
    logic [15:0] digits0, preset0, digits1, preset1;
    logic [2:0]  state0, state1;
    logic        done0, wrap0, done1, wrap1;

    always #5 clk_1HZ = ~clk_1HZ;

    ir_timer_n #(.DIGITS(4), .AUTO_RELOAD(1'b0)) u_dut0 (
        .clk_1HZ(clk_1HZ), .rst(rst), .ir_ready(ir_ready), .ir_in(ir_in),
        .digits(digits0), .preset(preset0), .state(state0), .done(done0), .wrap(wrap0)
    );

    ir_timer_n #(.DIGITS(4), .AUTO_RELOAD(1'b1)) u_dut1 (
        .clk_1HZ(clk_1HZ), .rst(rst), .ir_ready(ir_ready), .ir_in(ir_in),
        .digits(digits1), .preset(preset1), .state(state1), .done(done1), .wrap(wrap1)
    );

    typedef struct {
        int st;
        int cnt;
        int pre;
        bit dn;
        bit wr;
    } mdl_t;

    typedef struct {
        mdl_t m0;
        mdl_t m1;
    } exp_t;

    exp_t q[$];
    mdl_t ma, mb;
    int   errors = 0;
    int   checks = 0;

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int          p;
        r = 16'h0;
        p = v;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(p % 10);
            p = p / 10;
        end
        return r;
    endfunction

    // Reference behaviour: count and preset held as plain integers.
    function automatic mdl_t step(input mdl_t m, input bit r, input bit rdy,
                                  input logic [7:0] code, input bit auto_rl);
        mdl_t n;
        bit km, kc, ks, kd;
        n = m;
        n.dn = 1'b0;
        n.wr = 1'b0;
        if (r) begin
            n.st = 0; n.cnt = 0; n.pre = 0;
            return n;
        end
        km = rdy && (code == K_MODE);
        kc = rdy && !km && (code == K_CLEAR);
        ks = rdy && !km && !kc && (code == K_START);
        kd = rdy && !km && !kc && !ks && (code <= 8'd9);
        case (m.st)
            0, 1: begin
                if (km) begin n.st = 2; n.cnt = 0; n.pre = 0; end
                else if (kc) n.cnt = 0;
                else if (ks) n.st = 1 - m.st;
                else if (m.st == 0) begin
                    n.cnt = m.cnt + 1;
                    if (n.cnt == MOD) begin n.cnt = 0; n.wr = 1'b1; end
                end
            end
            2: begin
                if (km) begin n.st = 0; n.cnt = 0; end
                else if (kc) begin n.pre = 0; n.cnt = 0; end
                else if (ks) begin
                    if (m.pre != 0) begin n.st = 3; n.cnt = m.pre; end
                end else if (kd) begin
                    n.pre = (m.pre * 10 + int'(code)) % MOD;
                    n.cnt = n.pre;
                end
            end
            3, 4: begin
                if (km) begin n.st = 0; n.cnt = 0; end
                else if (kc) begin n.st = 2; n.cnt = 0; n.pre = 0; end
                else if (ks) n.st = 7 - m.st;
                else if (m.st == 3) begin
                    n.cnt = m.cnt - 1;
                    if (n.cnt == 0) begin n.st = 5; n.dn = 1'b1; end
                end
            end
            5: begin
                if (km) begin n.st = 0; n.cnt = 0; end
                else if (auto_rl) begin n.st = 3; n.cnt = m.pre; end
                else begin n.st = 2; n.cnt = 0; end
            end
            default: ;
        endcase
        return n;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cmp_dut(input string tag, input logic [15:0] d, input logic [15:0] p,
                           input logic [2:0] s, input logic dn, input logic wr, input mdl_t m);
        chk({tag, ".digits"}, 32'(d),  32'(to_bcd(m.cnt)));
        chk({tag, ".preset"}, 32'(p),  32'(to_bcd(m.pre)));
        chk({tag, ".state"},  32'(s),  32'(m.st));
        chk({tag, ".done"},   32'(dn), 32'(m.dn));
        chk({tag, ".wrap"},   32'(wr), 32'(m.wr));
    endtask

    // Applies one edge worth of inputs and queues the predicted outcome of that edge.
    task automatic drive(input bit r, input bit rdy, input logic [7:0] code);
        logic [31:0] w;
        exp_t        e;
        @(negedge clk_1HZ);
        w = $urandom;
        w[23:16] = code;
        rst = r;
        ir_ready = rdy;
        ir_in = w;
        ma = step(ma, r, rdy, code, 1'b0);
        mb = step(mb, r, rdy, code, 1'b1);
        e.m0 = ma;
        e.m1 = mb;
        q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 8'hFF);
    endtask

    task automatic key(input logic [7:0] code);
        drive(1'b0, 1'b1, code);
    endtask

    task automatic settle();
        @(posedge clk_1HZ);
        #1;
    endtask

    // Monitor: every edge with a queued prediction is compared on both instances.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk_1HZ);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                cmp_dut("ar0", digits0, preset0, state0, done0, wrap0, e.m0);
                cmp_dut("ar1", digits1, preset1, state1, done1, wrap1, e.m1);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int exp_seq[7];
        int sel;
        logic [7:0] code;
        exp_seq = '{2, 1, 0, 3, 2, 1, 0};
        ma = '{0, 0, 0, 1'b0, 1'b0};
        mb = '{0, 0, 0, 1'b0, 1'b0};

        // Reset, release, twelve ticks.
        drive(1'b1, 1'b0, 8'hFF);
        drive(1'b1, 1'b0, 8'hFF);
        idle(12);
        settle();
        chk("up12.digits", 32'(digits0), 32'h0012);
        chk("up12.state", 32'(state0), 32'd0);

        // Up-count rollover.
        drive(1'b1, 1'b0, 8'hFF);
        idle(9998);
        settle();
        chk("roll.9998", 32'(digits0), 32'h9998);
        idle(1);
        settle();
        chk("roll.9999", 32'(digits0), 32'h9999);
        chk("roll.nowrap", 32'(wrap0), 32'd0);
        idle(1);
        settle();
        chk("roll.zero", 32'(digits0), 32'h0000);
        chk("roll.wrap", 32'(wrap0), 32'd1);
        idle(1);
        settle();
        chk("roll.wrapdrop", 32'(wrap0), 32'd0);
        chk("roll.one", 32'(digits0), 32'h0001);

        // Countdown from 0015 to DONE, then back to SET.
        drive(1'b1, 1'b0, 8'hFF);
        key(K_MODE); key(8'h00); key(8'h00); key(8'h01); key(8'h05);
        key(K_START);
        idle(15);
        settle();
        chk("cd15.state", 32'(state0), 32'd5);
        chk("cd15.done", 32'(done0), 32'd1);
        chk("cd15.digits", 32'(digits0), 32'h0000);
        idle(1);
        settle();
        chk("cd15.set", 32'(state0), 32'd2);
        chk("cd15.clr", 32'(digits0), 32'h0000);
        chk("cd15.preset", 32'(preset0), 32'h0015);
        chk("cd15.donedrop", 32'(done0), 32'd0);

        // Auto-reload of preset 0003.
        drive(1'b1, 1'b0, 8'hFF);
        key(K_MODE); key(8'h03); key(K_START);
        settle();
        chk("ar.start", 32'(digits1), 32'h0003);
        for (int i = 0; i < 7; i++) begin
            idle(1);
            settle();
            chk("ar.seq", 32'(digits1), 32'(to_bcd(exp_seq[i])));
            chk("ar.done", 32'(done1), 32'(exp_seq[i] == 0));
        end

        // Pause and resume of a countdown at 0040.
        drive(1'b1, 1'b0, 8'hFF);
        key(K_MODE); key(8'h04); key(8'h00); key(K_START); key(K_START);
        settle();
        chk("hold.state", 32'(state0), 32'd4);
        chk("hold.digits", 32'(digits0), 32'h0040);
        for (int i = 0; i < 5; i++) begin
            idle(1);
            settle();
            chk("hold.keep", 32'(digits0), 32'h0040);
        end
        key(K_START);
        settle();
        chk("resume.state", 32'(state0), 32'd3);
        chk("resume.digits", 32'(digits0), 32'h0040);
        idle(1);
        settle();
        chk("resume.dec", 32'(digits0), 32'h0039);

        // Reset beats a simultaneous key mid-countdown.
        drive(1'b1, 1'b0, 8'hFF);
        key(K_MODE); key(8'h09); key(K_START);
        idle(3);
        drive(1'b1, 1'b1, K_START);
        settle();
        chk("rstkey.state", 32'(state0), 32'd0);
        chk("rstkey.digits", 32'(digits0), 32'h0000);
        chk("rstkey.preset", 32'(preset0), 32'h0000);
        chk("rstkey.done", 32'(done0), 32'd0);

        // Randomised key traffic with occasional resets.
        for (int i = 0; i < 4000; i++) begin
            sel = $urandom_range(0, 9);
            case (sel)
                0:       code = K_MODE;
                1:       code = K_CLEAR;
                2, 3:    code = K_START;
                4, 5, 6: code = 8'($urandom_range(0, 9));
                7:       code = 8'($urandom_range(1, 3));
                default: code = 8'($urandom);
            endcase
            drive($urandom_range(0, 299) == 0, $urandom_range(0, 99) < 25, code);
        end

        repeat (3) @(posedge clk_1HZ);
        #2;
        chk("queue.drained", 32'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ir_timer_n.md
IR_TIMER_N -- requirements
Module: ir_timer_n

Interface
REQ-001 SHALL have parameter DIGITS, default 4, number of BCD digits (legal 1..8).
REQ-002 SHALL have parameter KEY_MODE, default 8'h11, code that switches the up/down family.
REQ-003 SHALL have parameter KEY_START, default 8'h16, code for start/pause/resume.
REQ-004 SHALL have parameter KEY_CLEAR, default 8'h10, code for clear.
REQ-005 SHALL have parameter AUTO_RELOAD, default 0; when set to 1, countdown reloads the preset and restarts on expiry.
REQ-006 SHALL have port clk_1HZ  in  1  the only clock; every rising edge is one count tick.
REQ-007 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-008 SHALL have port ir_ready  in  1  key event valid this cycle.
REQ-009 SHALL have port ir_in  in  32  IR frame; key code is ir_in[23:16].
REQ-010 SHALL have port digits  out  4*DIGITS  packed BCD display; digit 0 is bits [3:0].
REQ-011 SHALL have port preset  out  4*DIGITS  packed BCD countdown preset.
REQ-012 SHALL have port state  out  3  state code: UP_RUN=0, UP_HOLD=1, SET=2, DOWN_RUN=3, DOWN_HOLD=4, DONE=5.
REQ-013 SHALL have port done  out  1  one-cycle pulse on countdown expiry.
REQ-014 SHALL have port wrap  out  1  one-cycle pulse on up-count rollover.

Function
REQ-015 SHALL treat a key event as ir_ready=1 at a clock edge, with the code sampled at that same edge (no extra input register); at most one key is processed per cycle.
REQ-016 SHALL implement the counter as per-digit BCD increment/decrement with ripple carry/borrow; no binary-to-BCD division.
REQ-017 SHALL update digits in the same edge as the count change, so the display never lags the count.
REQ-018 SHALL give key priority as KEY_MODE > KEY_CLEAR > KEY_START > digit keys (8'h00..8'h09); all other codes are ignored.
REQ-019 SHALL, on KEY_MODE in UP_RUN or UP_HOLD, go to SET with digits=0 and preset=0.
REQ-020 SHALL, on KEY_MODE in SET, DOWN_RUN, DOWN_HOLD or DONE, go to UP_RUN with digits=0.
REQ-021 UP_RUN SHALL increment digits by 1 each cycle without a key; all-9s+1 SHALL give 0 with wrap=1 for that cycle.
REQ-022 UP_RUN SHALL, on KEY_START, go to UP_HOLD with no increment that cycle.
REQ-023 UP_HOLD SHALL hold digits, and SHALL return to UP_RUN on KEY_START with no increment that cycle.
REQ-024 SHALL, on KEY_CLEAR in UP_RUN or UP_HOLD, set digits=0 and keep the state unchanged.
REQ-025 SET SHALL, on a digit key k, shift preset left one digit (MSD dropped, k into digit 0) and set digits to the new preset value in the same edge.
REQ-026 SET SHALL, on KEY_START with preset≠0, go to DOWN_RUN with digits=preset; KEY_START with preset=0 SHALL be ignored.
REQ-027 SET SHALL, on KEY_CLEAR, set preset=0 and digits=0.
REQ-028 DOWN_RUN SHALL decrement digits by 1 each cycle without a key.
REQ-029 DOWN_RUN SHALL go to DONE on the edge where digits goes from 1 to 0.
REQ-030 DOWN_RUN SHALL, on KEY_START, go to DOWN_HOLD with no decrement that cycle.
REQ-031 DOWN_RUN SHALL, on KEY_CLEAR, go to SET with digits=0 and preset=0.
REQ-032 DOWN_HOLD SHALL hold digits, go to DOWN_RUN on KEY_START, and go to SET with digits=0 and preset=0 on KEY_CLEAR.
REQ-033 DONE SHALL last exactly one cycle with done=1 and digits=0.
REQ-034 DONE SHALL next go to DOWN_RUN with digits=preset if AUTO_RELOAD=1, otherwise to SET with digits=0 and preset kept.
REQ-035 SHALL ignore all keys except KEY_MODE while in DONE.
REQ-036 SHALL keep preset unchanged in every state except SET (digit key or KEY_CLEAR), KEY_CLEAR in DOWN_RUN or DOWN_HOLD, and KEY_MODE from the up family.
REQ-037 SHALL register done and wrap, and SHALL drive them low in every cycle other than those defined above.

Reset
REQ-038 SHALL, when rst=1 at an edge, set state=UP_RUN, digits=0, preset=0, done=0 and wrap=0, with rst taking priority over every key.
REQ-039 SHALL, on the first edge after rst is released, behave as UP_RUN, so digits becomes 1.
REQ-040 SHALL apply reset the same way in any state, including mid-countdown and in DONE.

Verification (DIGITS=4)
REQ-041 SHALL check: reset, release, 12 edges -> digits=0012, state=0.
REQ-042 SHALL check: force up count to 9998, 2 edges -> 9999, then 0000 with wrap=1 for one cycle.
REQ-043 SHALL check: KEY_MODE, keys 0,0,1,5, KEY_START, 15 edges -> state=DONE with done=1, then state=SET, digits=0000, preset=0015.
REQ-044 SHALL check: AUTO_RELOAD=1, preset 0003 and start -> done pulses every 4 cycles, digits sequence 3,2,1,0,3,2.
REQ-045 SHALL check: countdown at 0040, KEY_START, 5 idle edges, KEY_START -> digits stays 0040 through the hold, then 0039 on the next edge.
REQ-046 SHALL check: rst=1 during DOWN_RUN together with KEY_START -> state=UP_RUN, digits=0000, preset=0000, done=0.
